// File: rtl/aac_stream_pkg.sv
// Shared definitions for the AAC multi-channel sample stream.
// Provides arbitration mode constants, the default PCM sample width, the
// packed sample record (error tag + PCM data) and the grant-lock state type.
package aac_stream_pkg;

  localparam int unsigned ARB_RR         = 0;  // round-robin arbitration
  localparam int unsigned ARB_PRIO       = 1;  // fixed priority, channel 0 highest
  localparam int unsigned DATA_W_DEFAULT = 16;

  typedef struct packed {
    logic                      err;
    logic [DATA_W_DEFAULT-1:0] data;
  } sample_t;

  // StLocked: a grant has been presented and is held until accepted.
  typedef enum logic {
    StFree,
    StLocked
  } grant_st_e;

endpackage

// File: rtl/aac_chan_fifo.sv
// Single-channel circular sample buffer.
// Ports:
//   clk_i, reset_i  - clock, asynchronous active-high reset
//   flush_i         - synchronous clear; dominates push and pop
//   push_i, wdata_i - write request and {err, data} word
//   pop_i, rdata_o  - read request and head-of-queue word
//   full_o, empty_o - occupancy flags
//   level_o         - current entry count, 0..DEPTH
module aac_chan_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 17,
  parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             push_w, pop_w;

  assign full_o  = (count_q == LVL_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Guard locally so a stray request can never corrupt the pointers.
  assign push_w = push_i && !full_o && !flush_i;
  assign pop_w  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Explicit wrap so DEPTH need not be a power of two.
      if (push_w) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop_w)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (push_w && !pop_w)      count_d = count_q + 1'b1;
      else if (pop_w && !push_w) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never read while empty, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push_w) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/aac_sample_fifo_mc.sv
// Multi-channel sample buffer merging per-channel PCM streams into one
// sample/error stream, with round-robin or fixed-priority output arbitration.
// Ports:
//   clk_i, reset_i     - clock, asynchronous active-high reset
//   flush_i            - synchronous clear of all FIFOs and the arbiter
//   in_valid_i/in_ready_o/in_data_i/in_err_i - per-channel push interface
//   out_valid_o/out_ready_i/out_data_o/out_ch_o/out_err_o - merged output
//   level_o            - per-channel occupancy, LVL_W bits per channel
module aac_sample_fifo_mc import aac_stream_pkg::*; #(
  parameter int unsigned DATA_W   = DATA_W_DEFAULT,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned N_CH     = 2,
  parameter int unsigned ARB_MODE = ARB_RR,
  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int unsigned LVL_W   = $clog2(DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    flush_i,
  input  logic [N_CH-1:0]         in_valid_i,
  output logic [N_CH-1:0]         in_ready_o,
  input  logic [N_CH*DATA_W-1:0]  in_data_i,
  input  logic [N_CH-1:0]         in_err_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DATA_W-1:0]       out_data_o,
  output logic [CH_W-1:0]         out_ch_o,
  output logic                    out_err_o,
  output logic [N_CH*LVL_W-1:0]   level_o
);

  localparam int unsigned SW = DATA_W + 1;

  logic [N_CH-1:0] full, empty, push, pop;
  logic [SW-1:0]   head [N_CH];
  logic [SW-1:0]   head_sel;
  logic            out_pop;

  grant_st_e       st_q, st_d;
  logic [CH_W-1:0] gnt_q, gnt_d, gnt, pick;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            found;
  int unsigned     idx;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    // Independent of out_ready: a full FIFO refuses even if it pops this cycle.
    assign in_ready_o[c] = !full[c] && !flush_i && !reset_i;
    assign push[c]       = in_valid_i[c] && in_ready_o[c];
    assign pop[c]        = out_pop && (gnt == CH_W'(c));

    aac_chan_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (SW),
      .LVL_W (LVL_W)
    ) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .flush_i (flush_i),
      .push_i  (push[c]),
      .wdata_i ({in_err_i[c], in_data_i[c*DATA_W +: DATA_W]}),
      .pop_i   (pop[c]),
      .rdata_o (head[c]),
      .full_o  (full[c]),
      .empty_o (empty[c]),
      .level_o (level_o[c*LVL_W +: LVL_W])
    );
  end

  // Candidate grant for when no grant is locked.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ARB_MODE == ARB_PRIO) begin
        idx = i;
      end else begin
        idx = int'(rr_ptr_q) + i;
        if (idx >= N_CH) idx = idx - N_CH;
      end
      if (!found && !empty[idx]) begin
        pick  = CH_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign gnt         = (st_q == StLocked) ? gnt_q : pick;
  assign out_valid_o = |(~empty);
  assign out_pop     = out_valid_o && out_ready_i && !flush_i;
  assign head_sel    = head[gnt];
  assign out_data_o  = out_valid_o ? head_sel[DATA_W-1:0] : '0;
  assign out_err_o   = out_valid_o ? head_sel[DATA_W] : 1'b0;
  assign out_ch_o    = out_valid_o ? gnt : '0;

  // Grant lock: a presented grant is frozen until the sink accepts it.
  always_comb begin
    st_d     = st_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    if (flush_i) begin
      st_d     = StFree;
      gnt_d    = '0;
      rr_ptr_d = '0;
    end else if (out_pop) begin
      st_d     = StFree;
      rr_ptr_d = (gnt == CH_W'(N_CH - 1)) ? '0 : gnt + 1'b1;
    end else if (out_valid_o) begin
      st_d  = StLocked;
      gnt_d = gnt;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      st_q     <= StFree;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      st_q     <= st_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_aac_sample_fifo_mc.sv
// Bench for aac_sample_fifo_mc: instance A (round-robin, 3 ch, depth 4) and
// instance B (fixed priority, 3 ch, depth 3), each with an expected-output
// queue consumed by its own monitor.
module tb_aac_sample_fifo_mc;
  import aac_stream_pkg::*;

  typedef struct {
    logic [1:0] ch;
    sample_t    s;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];

  // Instance A signals
  logic        a_reset, a_flush, a_out_ready, a_out_valid, a_out_err;
  logic [2:0]  a_in_valid, a_in_ready, a_in_err;
  logic [47:0] a_in_data;
  logic [15:0] a_out_data;
  logic [1:0]  a_out_ch;
  logic [8:0]  a_level;
  // Instance B signals
  logic        b_reset, b_flush, b_out_ready, b_out_valid, b_out_err;
  logic [2:0]  b_in_valid, b_in_ready, b_in_err;
  logic [47:0] b_in_data;
  logic [15:0] b_out_data;
  logic [1:0]  b_out_ch;
  logic [5:0]  b_level;

  aac_sample_fifo_mc #(.DATA_W(16), .DEPTH(4), .N_CH(3), .ARB_MODE(ARB_RR)) u_dut_a (
    .clk_i(clk), .reset_i(a_reset), .flush_i(a_flush),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
    .in_err_i(a_in_err), .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .out_data_o(a_out_data), .out_ch_o(a_out_ch), .out_err_o(a_out_err),
    .level_o(a_level)
  );

  aac_sample_fifo_mc #(.DATA_W(16), .DEPTH(3), .N_CH(3), .ARB_MODE(ARB_PRIO)) u_dut_b (
    .clk_i(clk), .reset_i(b_reset), .flush_i(b_flush),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .in_err_i(b_in_err), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .out_data_o(b_out_data), .out_ch_o(b_out_ch), .out_err_o(b_out_err),
    .level_o(b_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic ea(input logic [1:0] ch, input logic err, input logic [15:0] d);
    exp_t e;
    e.ch = ch; e.s.err = err; e.s.data = d;
    exp_a.push_back(e);
  endtask

  task automatic eb(input logic [1:0] ch, input logic err, input logic [15:0] d);
    exp_t e;
    e.ch = ch; e.s.err = err; e.s.data = d;
    exp_b.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_a();
    a_out_ready = 1'b1;
    for (int n = 0; n < 50 && a_out_valid; n++) step();
    chk("a_drain_done", a_out_valid, 0);
    chk("a_queue_empty", exp_a.size(), 0);
    a_out_ready = 1'b0;
  endtask

  task automatic drain_b();
    b_out_ready = 1'b1;
    for (int n = 0; n < 50 && b_out_valid; n++) step();
    chk("b_drain_done", b_out_valid, 0);
    chk("b_queue_empty", exp_b.size(), 0);
    b_out_ready = 1'b0;
  endtask

  // Monitor A: pops expectations on handshakes, checks hold while stalled.
  logic        a_pend = 1'b0, a_perr;
  logic [1:0]  a_pch;
  logic [15:0] a_pdat;
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_reset || a_flush) begin
      a_pend <= 1'b0;
    end else begin
      if (a_pend) begin
        chk("a_hold_valid", a_out_valid, 1);
        chk("a_hold_ch", a_out_ch, a_pch);
        chk("a_hold_data", a_out_data, a_pdat);
        chk("a_hold_err", a_out_err, a_perr);
      end
      if (a_out_valid && a_out_ready) begin
        if (exp_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected: got ch %0d data %0h, expected no output",
                   a_out_ch, a_out_data);
        end else begin
          e = exp_a.pop_front();
          chk("a_out_ch", a_out_ch, e.ch);
          chk("a_out_data", a_out_data, e.s.data);
          chk("a_out_err", a_out_err, e.s.err);
        end
      end
      a_pend <= a_out_valid && !a_out_ready;
      a_pch  <= a_out_ch;
      a_pdat <= a_out_data;
      a_perr <= a_out_err;
    end
  end

  // Monitor B
  logic        b_pend = 1'b0, b_perr;
  logic [1:0]  b_pch;
  logic [15:0] b_pdat;
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_reset || b_flush) begin
      b_pend <= 1'b0;
    end else begin
      if (b_pend) begin
        chk("b_hold_valid", b_out_valid, 1);
        chk("b_hold_ch", b_out_ch, b_pch);
        chk("b_hold_data", b_out_data, b_pdat);
        chk("b_hold_err", b_out_err, b_perr);
      end
      if (b_out_valid && b_out_ready) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: got ch %0d data %0h, expected no output",
                   b_out_ch, b_out_data);
        end else begin
          e = exp_b.pop_front();
          chk("b_out_ch", b_out_ch, e.ch);
          chk("b_out_data", b_out_data, e.s.data);
          chk("b_out_err", b_out_err, e.s.err);
        end
      end
      b_pend <= b_out_valid && !b_out_ready;
      b_pch  <= b_out_ch;
      b_pdat <= b_out_data;
      b_perr <= b_out_err;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int  k;
    int  cyc;
    logic acc;
    a_reset = 1'b1; a_flush = 1'b0; a_out_ready = 1'b0;
    a_in_valid = '0; a_in_data = '0; a_in_err = '0;
    b_reset = 1'b1; b_flush = 1'b0; b_out_ready = 1'b0;
    b_in_valid = '0; b_in_data = '0; b_in_err = '0;
    #3;
    chk("a_rst_in_ready", a_in_ready, 0);
    chk("a_rst_out_valid", a_out_valid, 0);
    chk("a_rst_level", a_level, 0);
    chk("b_rst_in_ready", b_in_ready, 0);
    step(); step();
    a_reset = 1'b0; b_reset = 1'b0;
    #1;
    chk("a_ready_after_rst", a_in_ready, 3'b111);
    chk("a_out_data_rst", a_out_data, 0);

    // Single push on ch1, visible the next cycle.
    a_in_valid = 3'b010; a_in_data[31:16] = 16'h1234; a_in_err = 3'b000;
    step();
    a_in_valid = '0;
    chk("t1_valid", a_out_valid, 1);
    chk("t1_ch", a_out_ch, 1);
    chk("t1_data", a_out_data, 16'h1234);
    chk("t1_err", a_out_err, 0);
    chk("t1_level1", a_level[5:3], 1);
    ea(2'd1, 1'b0, 16'h1234);
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    chk("t1_level1_after", a_level[5:3], 0);
    chk("t1_valid_after", a_out_valid, 0);

    // Fill ch0 with 5 pushes; the 5th must be refused.
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 3'b001; a_in_data[15:0] = 16'hA000 + 16'(i);
      step();
      if (i == 3) chk("t2_full_ready", a_in_ready[0], 0);
    end
    a_in_valid = '0;
    chk("t2_level0", a_level[2:0], 4);
    ea(2'd0, 1'b0, 16'hA000);
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    chk("t2_ready_back", a_in_ready[0], 1);
    chk("t2_level0_3", a_level[2:0], 3);
    ea(2'd0, 1'b0, 16'hA001); ea(2'd0, 1'b0, 16'hA002); ea(2'd0, 1'b0, 16'hA003);
    drain_a();

    // Flush with simultaneous push and pop.
    a_in_valid = 3'b011; a_in_data[15:0] = 16'hC000; a_in_data[31:16] = 16'hC100;
    step();
    a_in_data[15:0] = 16'hC001; a_in_data[31:16] = 16'hC101;
    step();
    a_in_valid = 3'b001; a_in_data[15:0] = 16'hC002;
    step();
    a_in_valid = '0;
    chk("t3_level0", a_level[2:0], 3);
    chk("t3_level1", a_level[5:3], 2);
    a_flush = 1'b1; a_in_valid = 3'b001; a_in_data[15:0] = 16'hDEAD; a_out_ready = 1'b1;
    #1;
    chk("t3_ready_in_flush", a_in_ready, 0);
    step();
    a_flush = 1'b0; a_in_valid = '0; a_out_ready = 1'b0;
    chk("t3_levels", a_level, 0);
    chk("t3_valid", a_out_valid, 0);

    // Round-robin: 2 samples per channel -> 0,1,2,0,1,2.
    a_in_valid = 3'b111; a_in_data = {16'h3200, 16'h3100, 16'h3000}; a_in_err = 3'b101;
    step();
    a_in_data = {16'h3201, 16'h3101, 16'h3001}; a_in_err = 3'b010;
    step();
    a_in_valid = '0; a_in_err = '0;
    ea(2'd0, 1'b1, 16'h3000); ea(2'd1, 1'b0, 16'h3100); ea(2'd2, 1'b1, 16'h3200);
    ea(2'd0, 1'b0, 16'h3001); ea(2'd1, 1'b1, 16'h3101); ea(2'd2, 1'b0, 16'h3201);
    drain_a();

    // Fixed priority: same load -> 0,0,1,1,2,2.
    b_in_valid = 3'b111; b_in_data = {16'h2200, 16'h2100, 16'h2000}; b_in_err = 3'b000;
    step();
    b_in_data = {16'h2201, 16'h2101, 16'h2001}; b_in_err = 3'b111;
    step();
    b_in_valid = '0; b_in_err = '0;
    eb(2'd0, 1'b0, 16'h2000); eb(2'd0, 1'b1, 16'h2001); eb(2'd1, 1'b0, 16'h2100);
    eb(2'd1, 1'b1, 16'h2101); eb(2'd2, 1'b0, 16'h2200); eb(2'd2, 1'b1, 16'h2201);
    drain_b();

    // Locked ch2 grant survives ch0 filling up.
    b_in_valid = 3'b100; b_in_data[47:32] = 16'h2222; b_in_err = 3'b100;
    step();
    b_in_err = '0;
    chk("p2_ch_locked", b_out_ch, 2);
    for (int i = 0; i < 3; i++) begin
      b_in_valid = 3'b001; b_in_data[15:0] = 16'h0A00 + 16'(i);
      step();
      chk("p2_ch_hold", b_out_ch, 2);
    end
    b_in_valid = '0;
    eb(2'd2, 1'b1, 16'h2222); eb(2'd0, 1'b0, 16'h0A00);
    eb(2'd0, 1'b0, 16'h0A01); eb(2'd0, 1'b0, 16'h0A02);
    drain_b();

    // Error tags across pointer wrap with random backpressure.
    k = 0; cyc = 0;
    while (k < 10 && cyc < 200) begin
      b_in_valid = 3'b001; b_in_data[15:0] = 16'h5000 + 16'(k);
      b_in_err[0] = (k % 2 == 0);
      b_out_ready = 1'($urandom_range(0, 1));
      acc = b_in_ready[0];
      step();
      if (acc) begin
        eb(2'd0, (k % 2 == 0), 16'h5000 + 16'(k));
        k++;
      end
      cyc++;
    end
    b_in_valid = '0; b_in_err = '0;
    chk("p3_pushes", k, 10);
    drain_b();

    // Async reset mid-stream drops the pending output immediately.
    b_in_valid = 3'b001; b_in_data[15:0] = 16'h6000;
    step();
    b_in_data[15:0] = 16'h6001;
    step();
    b_in_valid = '0;
    chk("r_valid_before", b_out_valid, 1);
    #2 b_reset = 1'b1;
    #1;
    chk("r_valid_async", b_out_valid, 0);
    chk("r_ready_async", b_in_ready, 0);
    chk("r_level_async", b_level, 0);
    step(); step();
    b_reset = 1'b0;
    step(); step(); step();
    chk("r_no_replay", b_out_valid, 0);
    chk("end_queue_a", exp_a.size(), 0);
    chk("end_queue_b", exp_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
